// File: rtl/pla_sweep_ctrl_if.sv
// Harness-side bundle for the PLA sweep controller: run control, captured range,
// the vector/response pair of the function under test, and the run results.
interface pla_sweep_ctrl_if #(
    parameter int N_IN     = 21,
    parameter int CNT_W    = 22,
    parameter int SIG_W    = 32,
    parameter int SETTLE_W = 4
);
    logic                start;
    logic                abort;
    logic [N_IN-1:0]     first_vec;
    logic [N_IN-1:0]     last_vec;
    logic [SETTLE_W-1:0] settle;
    logic [N_IN-1:0]     dut_x;
    logic                dut_y;
    logic                busy;
    logic                done;
    logic [CNT_W-1:0]    ones_cnt;
    logic [CNT_W-1:0]    vec_cnt;
    logic [SIG_W-1:0]    signature;

    modport master (
        output start, abort, first_vec, last_vec, settle, dut_y,
        input  dut_x, busy, done, ones_cnt, vec_cnt, signature
    );

    modport slave (
        input  start, abort, first_vec, last_vec, settle, dut_y,
        output dut_x, busy, done, ones_cnt, vec_cnt, signature
    );
endinterface

// File: rtl/pla_sweep_ctrl.sv
// Sweeps a contiguous (optionally wrapping) vector range into a combinational
// function and accumulates ON-set count, vector count and a MISR of its output.
module pla_sweep_ctrl #(
    parameter int              N_IN     = 21,
    parameter int              CNT_W    = 22,
    parameter int              SIG_W    = 32,
    parameter logic [31:0]     POLY     = 32'h04C11DB7,
    parameter int              SETTLE_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    pla_sweep_ctrl_if.slave  bus
);
    localparam logic [SIG_W-1:0] POLY_L = SIG_W'(POLY);

    typedef enum logic [2:0] {
        S_IDLE,
        S_APPLY,
        S_WAIT,
        S_SAMPLE,
        S_DONE
    } state_t;

    state_t              state_q,  state_d;
    logic [N_IN-1:0]     dut_x_q,  dut_x_d;
    logic [N_IN-1:0]     last_q,   last_d;
    logic [SETTLE_W-1:0] settle_q, settle_d;
    logic [SETTLE_W-1:0] wait_q,   wait_d;
    logic [CNT_W-1:0]    ones_q,   ones_d;
    logic [CNT_W-1:0]    vec_q,    vec_d;
    logic [SIG_W-1:0]    sig_q,    sig_d;
    logic                busy_q,   busy_d;
    logic                done_q,   done_d;

    logic [SIG_W-1:0]    sig_step;

    assign sig_step = {sig_q[SIG_W-2:0], 1'b0}
                    ^ (sig_q[SIG_W-1] ? POLY_L : '0)
                    ^ {{(SIG_W-1){1'b0}}, bus.dut_y};

    always_comb begin
        state_d  = state_q;
        dut_x_d  = dut_x_q;
        last_d   = last_q;
        settle_d = settle_q;
        wait_d   = wait_q;
        ones_d   = ones_q;
        vec_d    = vec_q;
        sig_d    = sig_q;
        busy_d   = busy_q;
        done_d   = 1'b0;

        // busy_q is high exactly in APPLY/WAIT/SAMPLE, so abort pre-empts any
        // sample of this cycle and leaves the partial results untouched.
        if (busy_q && bus.abort) begin
            state_d = S_IDLE;
            busy_d  = 1'b0;
        end else begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (bus.start) begin
                        last_d   = bus.last_vec;
                        settle_d = bus.settle;
                        dut_x_d  = bus.first_vec;
                        ones_d   = '0;
                        vec_d    = '0;
                        sig_d    = '1;
                        busy_d   = 1'b1;
                        state_d  = S_APPLY;
                    end
                end
                S_APPLY: begin
                    if (settle_q == '0) begin
                        state_d = S_SAMPLE;
                    end else begin
                        wait_d  = settle_q;
                        state_d = S_WAIT;
                    end
                end
                S_WAIT: begin
                    wait_d = wait_q - 1'b1;
                    if (wait_q == SETTLE_W'(1)) begin
                        state_d = S_SAMPLE;
                    end
                end
                S_SAMPLE: begin
                    ones_d = ones_q + CNT_W'(bus.dut_y);
                    vec_d  = vec_q + 1'b1;
                    sig_d  = sig_step;
                    if (dut_x_q == last_q) begin
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        state_d = S_DONE;
                    end else begin
                        dut_x_d = dut_x_q + 1'b1;
                        state_d = S_APPLY;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                    busy_d  = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            dut_x_q  <= '0;
            last_q   <= '0;
            settle_q <= '0;
            wait_q   <= '0;
            ones_q   <= '0;
            vec_q    <= '0;
            sig_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            dut_x_q  <= dut_x_d;
            last_q   <= last_d;
            settle_q <= settle_d;
            wait_q   <= wait_d;
            ones_q   <= ones_d;
            vec_q    <= vec_d;
            sig_q    <= sig_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign bus.dut_x     = dut_x_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.ones_cnt  = ones_q;
    assign bus.vec_cnt   = vec_q;
    assign bus.signature = sig_q;
endmodule

// File: tb/tb_pla_sweep_ctrl.sv
// Directed bench for pla_sweep_ctrl at N_IN=4: table of sweep runs plus
// hand-written sequences for settle timing, abort, back-to-back start and reset.
module tb_pla_sweep_ctrl;
    localparam int N_IN     = 4;
    localparam int CNT_W    = 5;
    localparam int SIG_W    = 32;
    localparam int SETTLE_W = 4;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;
    int   mode;
    logic y_man;

    pla_sweep_ctrl_if #(.N_IN(N_IN), .CNT_W(CNT_W), .SIG_W(SIG_W), .SETTLE_W(SETTLE_W)) bus ();

    pla_sweep_ctrl #(
        .N_IN(N_IN), .CNT_W(CNT_W), .SIG_W(SIG_W),
        .POLY(32'h04C11DB7), .SETTLE_W(SETTLE_W)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // modes: 0 zero, 1 one, 2 x0, 3 golden x0&x1, 4 golden with minterm 5 flipped, 5 manual
    function automatic logic yfun(input int m, input logic [3:0] v);
        case (m)
            0: return 1'b0;
            1: return 1'b1;
            2: return v[0];
            3: return v[0] & v[1];
            4: return (v[0] & v[1]) ^ (v == 4'd5);
            default: return 1'b0;
        endcase
    endfunction

    always_comb begin
        if (mode == 5) bus.dut_y = y_man;
        else           bus.dut_y = yfun(mode, bus.dut_x);
    end

    function automatic logic [31:0] misr(input logic [31:0] s, input logic y);
        return {s[30:0], 1'b0} ^ (s[31] ? 32'h04C11DB7 : 32'h0) ^ {31'b0, y};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [3:0] f;
        logic [3:0] l;
        logic [3:0] s;
        int         m;
        int         nv;
        int         ones;
    } row_t;

    row_t        tbl [8];
    logic [31:0] res_sig  [8];
    logic [4:0]  res_ones [8];

    // Pulses start, then scrambles the range inputs to show they were captured.
    task automatic do_run(input logic [3:0] f, input logic [3:0] l, input logic [3:0] s,
                          output int cyc, output bit dx_ok);
        int         occ;
        logic [3:0] e;
        bus.first_vec = f;
        bus.last_vec  = l;
        bus.settle    = s;
        bus.start     = 1'b1;
        tick();
        bus.start     = 1'b0;
        bus.first_vec = ~f;
        bus.last_vec  = ~l;
        bus.settle    = s + 4'd3;
        occ   = int'(s) + 2;
        cyc   = 0;
        dx_ok = 1'b1;
        while (bus.done !== 1'b1 && cyc < 2000) begin
            e = f + 4'(cyc / occ);
            if (bus.dut_x !== e) dx_ok = 1'b0;
            tick();
            cyc++;
        end
    endtask

    task automatic run_row(input int i);
        int          cyc;
        bit          dx_ok;
        logic [31:0] es;
        logic [3:0]  v;
        mode = tbl[i].m;
        do_run(tbl[i].f, tbl[i].l, tbl[i].s, cyc, dx_ok);
        es = 32'hFFFF_FFFF;
        v  = tbl[i].f;
        for (int k = 0; k < tbl[i].nv; k++) begin
            es = misr(es, yfun(tbl[i].m, v));
            v  = v + 4'd1;
        end
        $display("row %0d: first=%0d last=%0d settle=%0d cycles=%0d vec=%0d ones=%0d sig=%08h",
                 i, tbl[i].f, tbl[i].l, tbl[i].s, cyc, bus.vec_cnt, bus.ones_cnt, bus.signature);
        chk($sformatf("row%0d_cycles", i), 64'(cyc), 64'(tbl[i].nv * (int'(tbl[i].s) + 2)));
        chk($sformatf("row%0d_done", i), 64'(bus.done), 64'd1);
        chk($sformatf("row%0d_vec", i), 64'(bus.vec_cnt), 64'(tbl[i].nv));
        chk($sformatf("row%0d_ones", i), 64'(bus.ones_cnt), 64'(tbl[i].ones));
        chk($sformatf("row%0d_sig", i), 64'(bus.signature), 64'(es));
        chk($sformatf("row%0d_xseq", i), 64'(dx_ok), 64'd1);
        chk($sformatf("row%0d_xlast", i), 64'(bus.dut_x), 64'(tbl[i].l));
        res_sig[i]  = bus.signature;
        res_ones[i] = bus.ones_cnt;
        tick();
        chk($sformatf("row%0d_done_pulse", i), 64'(bus.done), 64'd0);
        chk($sformatf("row%0d_busy_after", i), 64'(bus.busy), 64'd0);
    endtask

    initial begin
        int          cyc;
        bit          dx_ok;
        logic [31:0] es;
        bit          saw_done;

        total = 0;
        bad   = 0;
        mode  = 2;
        y_man = 1'b0;
        tbl[0] = '{f: 4'd0,  l: 4'd15, s: 4'd0, m: 2, nv: 16, ones: 8};
        tbl[1] = '{f: 4'd14, l: 4'd1,  s: 4'd0, m: 1, nv: 4,  ones: 4};
        tbl[2] = '{f: 4'd5,  l: 4'd5,  s: 4'd3, m: 2, nv: 1,  ones: 1};
        tbl[3] = '{f: 4'd0,  l: 4'd15, s: 4'd1, m: 3, nv: 16, ones: 4};
        tbl[4] = '{f: 4'd0,  l: 4'd15, s: 4'd1, m: 4, nv: 16, ones: 5};
        tbl[5] = '{f: 4'd10, l: 4'd12, s: 4'd2, m: 2, nv: 3,  ones: 1};
        tbl[6] = '{f: 4'd15, l: 4'd0,  s: 4'd0, m: 2, nv: 2,  ones: 1};
        tbl[7] = '{f: 4'd7,  l: 4'd7,  s: 4'd0, m: 0, nv: 1,  ones: 0};

        rst_n         = 1'b0;
        bus.start     = 1'b0;
        bus.abort     = 1'b0;
        bus.first_vec = '0;
        bus.last_vec  = '0;
        bus.settle    = '0;
        tick();
        tick();
        chk("rst_dut_x", 64'(bus.dut_x), 64'd0);
        chk("rst_busy", 64'(bus.busy), 64'd0);
        chk("rst_done", 64'(bus.done), 64'd0);
        chk("rst_vec", 64'(bus.vec_cnt), 64'd0);
        chk("rst_ones", 64'(bus.ones_cnt), 64'd0);
        chk("rst_sig", 64'(bus.signature), 64'd0);
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < 8; i++) run_row(i);

        chk("golden_vs_mutant_sig_differs", 64'(res_sig[3] != res_sig[4]), 64'd1);
        chk("golden_vs_mutant_ones_delta", 64'(res_ones[4] - res_ones[3]), 64'd1);

        // Settle=3 on one vector: y is 1 only in the fifth cycle, so it must be sampled there.
        mode          = 5;
        y_man         = 1'b0;
        bus.first_vec = 4'd5;
        bus.last_vec  = 4'd5;
        bus.settle    = 4'd3;
        bus.start     = 1'b1;
        tick();
        bus.start     = 1'b0;
        for (int i = 0; i < 5; i++) begin
            $display("settle cycle %0d: dut_x=%0d vec=%0d busy=%0d", i, bus.dut_x, bus.vec_cnt, bus.busy);
            chk($sformatf("settle_x_c%0d", i), 64'(bus.dut_x), 64'd5);
            chk($sformatf("settle_vec_c%0d", i), 64'(bus.vec_cnt), 64'd0);
            if (i == 4) y_man = 1'b1;
            tick();
        end
        y_man = 1'b0;
        chk("settle_done", 64'(bus.done), 64'd1);
        chk("settle_vec", 64'(bus.vec_cnt), 64'd1);
        chk("settle_ones", 64'(bus.ones_cnt), 64'd1);
        chk("settle_sig", 64'(bus.signature), 64'(misr(32'hFFFF_FFFF, 1'b1)));

        // Abort after three samples, with a start pulse ignored while busy.
        mode          = 2;
        bus.first_vec = 4'd0;
        bus.last_vec  = 4'd15;
        bus.settle    = 4'd0;
        bus.start     = 1'b1;
        tick();
        bus.start     = 1'b0;
        tick();
        bus.first_vec = 4'd9;
        bus.start     = 1'b1;
        tick();
        bus.start     = 1'b0;
        cyc = 0;
        while (bus.vec_cnt !== 5'd3 && cyc < 100) begin
            tick();
            cyc++;
        end
        chk("abort_reach3_in_time", 64'(cyc < 100), 64'd1);
        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0;
        es = misr(misr(misr(32'hFFFF_FFFF, 1'b0), 1'b1), 1'b0);
        $display("abort: busy=%0d vec=%0d ones=%0d dut_x=%0d sig=%08h",
                 bus.busy, bus.vec_cnt, bus.ones_cnt, bus.dut_x, bus.signature);
        chk("abort_busy", 64'(bus.busy), 64'd0);
        chk("abort_vec", 64'(bus.vec_cnt), 64'd3);
        chk("abort_ones", 64'(bus.ones_cnt), 64'd1);
        chk("abort_sig", 64'(bus.signature), 64'(es));
        chk("abort_dut_x", 64'(bus.dut_x), 64'd3);
        saw_done = 1'b0;
        for (int i = 0; i < 6; i++) begin
            if (bus.done === 1'b1) saw_done = 1'b1;
            tick();
        end
        chk("abort_no_done", 64'(saw_done), 64'd0);
        chk("abort_vec_held", 64'(bus.vec_cnt), 64'd3);

        // Start and abort together in IDLE: start wins and counters clear.
        bus.first_vec = 4'd6;
        bus.start     = 1'b1;
        bus.abort     = 1'b1;
        tick();
        bus.start     = 1'b0;
        bus.abort     = 1'b0;
        chk("restart_busy", 64'(bus.busy), 64'd1);
        chk("restart_vec", 64'(bus.vec_cnt), 64'd0);
        chk("restart_ones", 64'(bus.ones_cnt), 64'd0);
        chk("restart_sig", 64'(bus.signature), 64'hFFFF_FFFF);
        chk("restart_dut_x", 64'(bus.dut_x), 64'd6);
        tick();
        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0;
        chk("abort_on_sample_busy", 64'(bus.busy), 64'd0);
        chk("abort_on_sample_vec", 64'(bus.vec_cnt), 64'd0);
        chk("abort_on_sample_sig", 64'(bus.signature), 64'hFFFF_FFFF);

        // Start in the DONE cycle begins the next run immediately.
        mode = 2;
        do_run(4'd2, 4'd3, 4'd0, cyc, dx_ok);
        chk("b2b_first_done", 64'(bus.done), 64'd1);
        bus.first_vec = 4'd8;
        bus.last_vec  = 4'd9;
        bus.settle    = 4'd0;
        bus.start     = 1'b1;
        tick();
        bus.start     = 1'b0;
        chk("b2b_busy", 64'(bus.busy), 64'd1);
        chk("b2b_done_low", 64'(bus.done), 64'd0);
        chk("b2b_vec_cleared", 64'(bus.vec_cnt), 64'd0);
        cyc = 0;
        while (bus.done !== 1'b1 && cyc < 100) begin
            tick();
            cyc++;
        end
        $display("b2b: cycles=%0d vec=%0d ones=%0d", cyc, bus.vec_cnt, bus.ones_cnt);
        chk("b2b_cycles", 64'(cyc), 64'd4);
        chk("b2b_ones", 64'(bus.ones_cnt), 64'd1);
        tick();

        // Asynchronous reset in the middle of WAIT.
        bus.first_vec = 4'd9;
        bus.last_vec  = 4'd15;
        bus.settle    = 4'd5;
        bus.start     = 1'b1;
        tick();
        bus.start     = 1'b0;
        tick();
        tick();
        chk("prerst_busy", 64'(bus.busy), 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        $display("midrun reset: dut_x=%0d busy=%0d sig=%08h", bus.dut_x, bus.busy, bus.signature);
        chk("arst_dut_x", 64'(bus.dut_x), 64'd0);
        chk("arst_busy", 64'(bus.busy), 64'd0);
        chk("arst_done", 64'(bus.done), 64'd0);
        chk("arst_vec", 64'(bus.vec_cnt), 64'd0);
        chk("arst_ones", 64'(bus.ones_cnt), 64'd0);
        chk("arst_sig", 64'(bus.signature), 64'd0);
        tick();
        rst_n = 1'b1;
        tick();
        chk("arst_idle_busy", 64'(bus.busy), 64'd0);
        run_row(0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/pla_sweep_ctrl.md
Name: pla_sweep_ctrl

Overview:
- Sequencer that drives an N_IN-input, single-output combinational benchmark function (inputs x0..x(N_IN-1), output y0) over a contiguous, optionally wrapping range of input vectors.
- Per run it accumulates the ON-set count, the number of vectors evaluated, and a MISR signature of the output stream.
- Sits between the equivalence/regression harness and the function under test; used to compare optimized netlists against their PLA originals without per-vector host traffic.

Parameters:
- N_IN, 21, width of the input vector driven to the function under test.
- CNT_W, 22, counter width; must be at least N_IN+1 so a full 2^N_IN sweep is representable.
- SIG_W, 32, MISR width.
- POLY, 32'h04C11DB7, MISR feedback polynomial (low SIG_W bits used).
- SETTLE_W, 4, width of the settle input.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  begin a run; sampled in IDLE and DONE only
- abort  in  1  terminate the current run
- first_vec  in  N_IN  first vector applied; captured at start
- last_vec  in  N_IN  final vector applied; captured at start
- settle  in  SETTLE_W  extra wait cycles per vector; captured at start
- dut_x  out  N_IN  vector driven to the function under test
- dut_y  in  1  function output y0
- busy  out  1  high while a run is in progress
- done  out  1  one-cycle pulse when a run completes normally
- ones_cnt  out  CNT_W  number of sampled vectors with dut_y=1
- vec_cnt  out  CNT_W  number of vectors sampled
- signature  out  SIG_W  MISR state

Behaviour:
- Reset (asynchronous, rst_n=0):
  - dut_x=0, busy=0, done=0, ones_cnt=0, vec_cnt=0, signature=0.
  - FSM goes to IDLE; captured registers cleared.
- FSM states are IDLE, APPLY, WAIT, SAMPLE and DONE.
  - IDLE/DONE with start=1: capture first_vec, last_vec and settle; dut_x<=first_vec; clear ones_cnt and vec_cnt; signature<=all-ones; busy<=1; go to APPLY.
  - APPLY: dut_x is stable. If settle_q=0, go to SAMPLE; otherwise load the wait counter with settle_q and go to WAIT.
  - WAIT: decrement the wait counter; go to SAMPLE when it reaches 1.
  - SAMPLE:
    - ones_cnt += dut_y; vec_cnt += 1.
    - signature <= {signature[SIG_W-2:0],1'b0} ^ (signature[SIG_W-1] ? POLY : 0) ^ {{SIG_W-1{0}},dut_y}.
    - If dut_x==last_q: busy<=0, done<=1, go to DONE.
    - Otherwise dut_x<=dut_x+1 (mod 2^N_IN) and go to APPLY.
  - DONE: done deasserts after one cycle. Results and dut_x are held until the next start.
- Per-vector occupancy is exactly settle+2 cycles: APPLY, settle cycles of WAIT, then SAMPLE. dut_y is sampled in the final cycle of that occupancy.
- Range rules:
  - first_vec==last_vec gives exactly one vector.
  - first_vec>last_vec wraps through 2^N_IN-1 to 0 and stops at last_vec.
  - first=0, last=2^N_IN-1 evaluates all 2^N_IN vectors; vec_cnt=2^N_IN with no counter overflow.
- Handshake rules:
  - start while busy is ignored.
  - first_vec, last_vec and settle may change during a run without effect.
  - A start in the same cycle as done (DONE state) begins a new run immediately.
- Abort rules:
  - abort=1 while busy: go to IDLE next cycle with busy=0 and no done pulse; ones_cnt, vec_cnt and signature hold their partial values; dut_x holds.
  - abort in IDLE/DONE is ignored.
  - abort and start in the same cycle in IDLE/DONE: start wins.
  - If abort coincides with SAMPLE, abort wins and that sample is discarded.
- Reset asserted mid-run returns everything to reset values immediately; no done pulse.
- All outputs are registered; dut_x never glitches between vectors.

Test Plan:
1. N_IN=4, settle=0, first=0, last=15, dut_y=dut_x[0] -> vec_cnt=16, ones_cnt=8, done pulses once 32 cycles after the first APPLY, busy low afterwards.
2. N_IN=4, first=14, last=1, dut_y=1 -> dut_x sequence is 14,15,0,1; vec_cnt=4, ones_cnt=4.
3. first=last=5, settle=3 -> dut_x=5 for 5 cycles; single sample in the fifth cycle; vec_cnt=1; signature equals the model's one-step MISR from all-ones with the sampled bit.
4. Full run with a golden model of the function as dut_y versus a mutated model (one flipped minterm) -> signatures differ; ones_cnt differs by exactly 1.
5. abort asserted after 3 samples, with start pulsed while busy -> busy drops the next cycle, vec_cnt=3 held, no done, the ignored start has no effect; a following start restarts with cleared counters.
6. rst_n pulled low mid-WAIT -> all outputs 0 asynchronously, FSM in IDLE; first start after release behaves as in scenario 1.
